// File: rtl/reg_file_mp.sv
// reg_file_mp: parametrised multi-port register file for the datapath.
// Decode reads it and writeback writes it.
//
// Ports:
//   clk          clock; all state updates happen on the rising edge
//   rst          synchronous active-high reset; clears storage, registered
//                read data, rd_valid and wr_collision
//   rd_en        per-port read request            [NUM_RD]
//   rd_addr      packed read addresses            [NUM_RD*WIDTH_ADDR]
//   rd_data      packed read data                 [NUM_RD*WIDTH_DATA]
//   rd_valid     per-port read data valid         [NUM_RD]
//   wr_en        per-port write enable            [NUM_WR]
//   wr_addr      packed write addresses           [NUM_WR*WIDTH_ADDR]
//   wr_data      packed write data                [NUM_WR*WIDTH_DATA]
//   wr_collision registered pulse; two or more kept writes hit one address
//                in the previous cycle
//
// Read handshake: there is no back-pressure. A read port issues rd_en, and
// rd_valid marks the cycle in which rd_data holds the answer. That cycle is
// the same cycle when RD_REG=0 and the next cycle when RD_REG=1. Write ports
// are fire-and-forget; wr_en commits the write on the next rising edge.
module reg_file_mp #(
  parameter int WIDTH_ADDR = 5,
  parameter int WIDTH_DATA = 32,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 1,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1,
  parameter int RD_REG     = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_RD-1:0]            rd_en,
  input  logic [NUM_RD*WIDTH_ADDR-1:0] rd_addr,
  output logic [NUM_RD*WIDTH_DATA-1:0] rd_data,
  output logic [NUM_RD-1:0]            rd_valid,
  input  logic [NUM_WR-1:0]            wr_en,
  input  logic [NUM_WR*WIDTH_ADDR-1:0] wr_addr,
  input  logic [NUM_WR*WIDTH_DATA-1:0] wr_data,
  output logic                         wr_collision
);

  localparam int DEPTH = 2 ** WIDTH_ADDR;

  logic [WIDTH_DATA-1:0] mem [DEPTH];
  logic [NUM_WR-1:0]     wr_keep;
  logic                  coll_next;
  logic [WIDTH_DATA-1:0] rd_eff [NUM_RD];

  // A write survives unless it targets the hardwired zero entry.
  always_comb begin
    wr_keep = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      wr_keep[j] = wr_en[j] &&
                   !((ZERO_REG != 0) && (wr_addr[j*WIDTH_ADDR +: WIDTH_ADDR] == '0));
    end
  end

  // Storage. Ports are applied in ascending order, so when several ports hit
  // the same entry the last assignment (highest index) wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int e = 0; e < DEPTH; e++) begin
        mem[e] <= '0;
      end
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_keep[j]) begin
          mem[wr_addr[j*WIDTH_ADDR +: WIDTH_ADDR]] <= wr_data[j*WIDTH_DATA +: WIDTH_DATA];
        end
      end
    end
  end

  // Collision: any pair of kept writes sharing an address. Dropped zero-entry
  // writes are already excluded by wr_keep.
  always_comb begin
    coll_next = 1'b0;
    for (int j = 0; j < NUM_WR; j++) begin
      for (int k = j + 1; k < NUM_WR; k++) begin
        if (wr_keep[j] && wr_keep[k] &&
            (wr_addr[j*WIDTH_ADDR +: WIDTH_ADDR] == wr_addr[k*WIDTH_ADDR +: WIDTH_ADDR])) begin
          coll_next = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_collision <= 1'b0;
    end else begin
      wr_collision <= coll_next;
    end
  end

  // Effective read value. Bypass uses the same ascending scan as the write,
  // so the forwarded data matches what the entry will hold after the edge.
  // During reset the pending writes are discarded, so nothing is forwarded.
  always_comb begin
    for (int i = 0; i < NUM_RD; i++) begin
      rd_eff[i] = mem[rd_addr[i*WIDTH_ADDR +: WIDTH_ADDR]];
      if ((BYPASS != 0) && !rst) begin
        for (int j = 0; j < NUM_WR; j++) begin
          if (wr_keep[j] &&
              (wr_addr[j*WIDTH_ADDR +: WIDTH_ADDR] == rd_addr[i*WIDTH_ADDR +: WIDTH_ADDR])) begin
            rd_eff[i] = wr_data[j*WIDTH_DATA +: WIDTH_DATA];
          end
        end
      end
      if ((ZERO_REG != 0) && (rd_addr[i*WIDTH_ADDR +: WIDTH_ADDR] == '0)) begin
        rd_eff[i] = '0;
      end
    end
  end

  generate
    if (RD_REG != 0) begin : g_rd_reg
      // Registered read. rd_data holds its value on ports that are not
      // reading, so a consumer may sample it late.
      always_ff @(posedge clk) begin
        if (rst) begin
          rd_data  <= '0;
          rd_valid <= '0;
        end else begin
          rd_valid <= rd_en;
          for (int i = 0; i < NUM_RD; i++) begin
            if (rd_en[i]) begin
              rd_data[i*WIDTH_DATA +: WIDTH_DATA] <= rd_eff[i];
            end
          end
        end
      end
    end else begin : g_rd_comb
      for (genvar i = 0; i < NUM_RD; i++) begin : g_port
        assign rd_data[i*WIDTH_DATA +: WIDTH_DATA] = rd_eff[i];
      end
      assign rd_valid = rd_en & {NUM_RD{~rst}};
    end
  endgenerate

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp. Three instances share one set of inputs:
//   dut_a: combinational read, write-first bypass
//   dut_b: combinational read, read-first (no bypass)
//   dut_c: registered read, write-first bypass
// All three have two read ports, two write ports and a hardwired zero entry.
module tb_reg_file_mp;

  localparam int WA = 5;
  localparam int WD = 32;

  logic          clk;
  logic          rst;
  logic [1:0]    rd_en;
  logic [WA-1:0] ra0, ra1;
  logic [1:0]    we;
  logic [WA-1:0] wa0, wa1;
  logic [WD-1:0] wd0, wd1;

  logic [2*WA-1:0] rd_addr;
  logic [2*WA-1:0] wr_addr;
  logic [2*WD-1:0] wr_data;
  assign rd_addr = {ra1, ra0};
  assign wr_addr = {wa1, wa0};
  assign wr_data = {wd1, wd0};

  logic [2*WD-1:0] a_data, b_data, c_data;
  logic [1:0]      a_valid, b_valid, c_valid;
  logic            a_coll, b_coll, c_coll;

  int errors = 0;
  int checks = 0;

  reg_file_mp #(.WIDTH_ADDR(WA), .WIDTH_DATA(WD), .NUM_RD(2), .NUM_WR(2),
                .ZERO_REG(1), .BYPASS(1), .RD_REG(0)) dut_a (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(a_data), .rd_valid(a_valid), .wr_en(we), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_collision(a_coll));

  reg_file_mp #(.WIDTH_ADDR(WA), .WIDTH_DATA(WD), .NUM_RD(2), .NUM_WR(2),
                .ZERO_REG(1), .BYPASS(0), .RD_REG(0)) dut_b (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(b_data), .rd_valid(b_valid), .wr_en(we), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_collision(b_coll));

  reg_file_mp #(.WIDTH_ADDR(WA), .WIDTH_DATA(WD), .NUM_RD(2), .NUM_WR(2),
                .ZERO_REG(1), .BYPASS(1), .RD_REG(1)) dut_c (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(c_data), .rd_valid(c_valid), .wr_en(we), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_collision(c_coll));

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic idle();
    rst = 1'b0; rd_en = 2'b00; we = 2'b00;
    ra0 = '0; ra1 = '0; wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0;
  endtask

  // Move to just after the next rising edge.
  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    // Test 1: reset, then reads of 0/5/31.
    rst = 1'b1; rd_en = 2'b11; ra0 = 5'd0; ra1 = 5'd5;
    after_edge();
    chk("rst_a_valid", {30'd0, a_valid}, 32'd0);
    chk("rst_a_p0", a_data[31:0], 32'd0);
    chk("rst_a_p1", a_data[63:32], 32'd0);
    chk("rst_b_p1", b_data[63:32], 32'd0);
    chk("rst_c_valid", {30'd0, c_valid}, 32'd0);
    chk("rst_c_p1", c_data[63:32], 32'd0);
    chk("rst_coll", {31'd0, a_coll}, 32'd0);

    rst = 1'b0; ra0 = 5'd31; ra1 = 5'd5;
    @(negedge clk);
    chk("post_rst_a_valid", {30'd0, a_valid}, 32'h3);
    chk("post_rst_a_p0", a_data[31:0], 32'd0);
    after_edge();
    chk("post_rst_c_valid", {30'd0, c_valid}, 32'h3);
    chk("post_rst_c_p0", c_data[31:0], 32'd0);

    // Test 2: write 0xDEADBEEF to 7 with a same-cycle read of 7.
    we = 2'b01; wa0 = 5'd7; wd0 = 32'hDEADBEEF; rd_en = 2'b01; ra0 = 5'd7; ra1 = 5'd7;
    @(negedge clk);
    chk("byp_a_p0", a_data[31:0], 32'hDEADBEEF);
    chk("byp_a_p1", a_data[63:32], 32'hDEADBEEF);
    chk("nobyp_b_p0", b_data[31:0], 32'd0);
    chk("byp_a_valid", {30'd0, a_valid}, 32'h1);
    after_edge();
    chk("byp_c_p0", c_data[31:0], 32'hDEADBEEF);
    chk("byp_c_valid", {30'd0, c_valid}, 32'h1);
    we = 2'b00;
    @(negedge clk);
    chk("rd7_a_p0", a_data[31:0], 32'hDEADBEEF);
    chk("rd7_b_p0", b_data[31:0], 32'hDEADBEEF);

    // Test 3: both ports write entry 0; reads of 0 stay 0, no collision.
    after_edge();
    we = 2'b11; wa0 = 5'd0; wa1 = 5'd0; wd0 = 32'h12345678; wd1 = 32'h87654321;
    rd_en = 2'b11; ra0 = 5'd0; ra1 = 5'd0;
    @(negedge clk);
    chk("zero_byp_a_p0", a_data[31:0], 32'd0);
    chk("zero_byp_a_p1", a_data[63:32], 32'd0);
    after_edge();
    chk("zero_c_p0", c_data[31:0], 32'd0);
    chk("zero_coll", {31'd0, a_coll}, 32'd0);
    we = 2'b00;
    @(negedge clk);
    chk("zero_b_p0", b_data[31:0], 32'd0);

    // Test 4: both ports write entry 3; port 1 wins, collision pulses once.
    after_edge();
    we = 2'b11; wa0 = 5'd3; wa1 = 5'd3; wd0 = 32'hAAAA0000; wd1 = 32'h5555FFFF;
    rd_en = 2'b01; ra0 = 5'd3;
    @(negedge clk);
    chk("coll_byp_a_p0", a_data[31:0], 32'h5555FFFF);
    chk("coll_old_b_p0", b_data[31:0], 32'd0);
    chk("coll_not_yet", {31'd0, a_coll}, 32'd0);
    after_edge();
    chk("coll_pulse_a", {31'd0, a_coll}, 32'd1);
    chk("coll_pulse_c", {31'd0, c_coll}, 32'd1);
    chk("coll_c_p0", c_data[31:0], 32'h5555FFFF);
    we = 2'b00;
    @(negedge clk);
    chk("coll_stored_b", b_data[31:0], 32'h5555FFFF);
    after_edge();
    chk("coll_clear", {31'd0, a_coll}, 32'd0);

    // Test 5: registered read with hold. Distinct-address writes do not collide.
    we = 2'b11; wa0 = 5'd10; wd0 = 32'h00000011; wa1 = 5'd9; wd1 = 32'h0000CAFE;
    rd_en = 2'b00;
    after_edge();
    chk("nocoll_distinct", {31'd0, a_coll}, 32'd0);
    we = 2'b00; rd_en = 2'b01; ra0 = 5'd9;
    after_edge();
    chk("rreg_c_p0", c_data[31:0], 32'h0000CAFE);
    chk("rreg_c_valid", {30'd0, c_valid}, 32'h1);
    rd_en = 2'b00; ra0 = 5'd10;
    @(negedge clk);
    chk("comb_noen_a_p0", a_data[31:0], 32'h00000011);
    chk("comb_noen_a_valid", {30'd0, a_valid}, 32'd0);
    after_edge();
    chk("rreg_hold_c_p0", c_data[31:0], 32'h0000CAFE);
    chk("rreg_hold_c_valid", {30'd0, c_valid}, 32'd0);

    // Test 6: reset together with colliding writes to entry 4 and a read.
    rst = 1'b1; we = 2'b11; wa0 = 5'd4; wa1 = 5'd4; wd0 = 32'hFFFFFFFF; wd1 = 32'hFFFFFFFF;
    rd_en = 2'b01; ra0 = 5'd9;
    after_edge();
    chk("mid_rst_c_p0", c_data[31:0], 32'd0);
    chk("mid_rst_c_valid", {30'd0, c_valid}, 32'd0);
    chk("mid_rst_coll", {31'd0, a_coll}, 32'd0);
    rst = 1'b0; we = 2'b00; rd_en = 2'b11; ra0 = 5'd4; ra1 = 5'd9;
    @(negedge clk);
    chk("mid_rst_a_p0", a_data[31:0], 32'd0);
    chk("mid_rst_a_p1", a_data[63:32], 32'd0);
    chk("mid_rst_b_p1", b_data[63:32], 32'd0);
    after_edge();
    chk("mid_rst_coll_after", {31'd0, a_coll}, 32'd0);
    chk("mid_rst_c_p1", c_data[63:32], 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
Parametrised multi-port register file, successor to the single-write/dual-read register file. Provides NUM_RD read ports and NUM_WR write ports. Options include a hardwired zero register, write-to-read bypass, and a registered read mode. Write collisions are detected and resolved by priority, and all storage is cleared on a synchronous reset. Sits in the processor datapath between decode (read) and writeback (write).

Parameters:
WIDTH_ADDR, 5, address width; DEPTH = 2**WIDTH_ADDR entries
WIDTH_DATA, 32, data width per entry
NUM_RD, 2, number of read ports (>=1)
NUM_WR, 1, number of write ports (>=1)
ZERO_REG, 1, 1 = entry 0 reads as 0 and ignores writes
BYPASS, 1, 1 = a same-cycle write to the read address is forwarded (write-first); 0 = old data returned (read-first)
RD_REG, 0, 0 = combinational read; 1 = read data registered, 1-cycle latency

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
rd_en  in  NUM_RD  per-port read request
rd_addr  in  NUM_RD*WIDTH_ADDR  packed read addresses, port i at [i*WIDTH_ADDR +: WIDTH_ADDR]
rd_data  out  NUM_RD*WIDTH_DATA  packed read data, port i at [i*WIDTH_DATA +: WIDTH_DATA]
rd_valid  out  NUM_RD  per-port read data valid
wr_en  in  NUM_WR  per-port write enable
wr_addr  in  NUM_WR*WIDTH_ADDR  packed write addresses
wr_data  in  NUM_WR*WIDTH_DATA  packed write data
wr_collision  out  1  registered pulse: two or more enabled write ports targeted the same address in the previous cycle

Behaviour:
- Reset: the design has one clock (clk). rst is synchronous and active-high. A rising edge of clk with rst=1 does all of the following:
  - sets every entry to 0
  - clears registered rd_data to 0
  - clears rd_valid (registered mode) to 0
  - clears wr_collision to 0
  - ignores all writes in that cycle
- Reset mid-operation discards any write or registered read presented in that cycle.
- Write:
  - At the rising edge with rst=0, each port j with wr_en[j]=1 writes wr_data[j] to wr_addr[j].
  - With ZERO_REG=1, writes to address 0 are dropped.
- Write collision:
  - If several enabled ports target the same address, the highest-index port wins.
  - wr_collision=1 in the following cycle only.
  - Writes dropped because they target address 0 (ZERO_REG=1) do not count toward a collision.
- Effective read value for port i:
  - If ZERO_REG=1 and rd_addr[i]=0: the value is 0.
  - Else if BYPASS=1 and some enabled write port targets rd_addr[i] in the same cycle (rst=0): the value is that port's wr_data, with highest-index priority.
  - Otherwise: the stored entry.
- RD_REG=0 (combinational read):
  - rd_data[i] is the effective read value in the same cycle, regardless of rd_en.
  - rd_valid[i] = rd_en[i] & ~rst, combinational.
  - Latency is 0.
- RD_REG=1 (registered read):
  - At the rising edge, if rd_en[i]=1, rd_data[i] is loaded with the effective read value.
  - If rd_en[i]=0, rd_data[i] holds its value.
  - rd_valid[i] is registered from rd_en[i] and is 0 after reset.
  - Latency is 1 cycle.
  - BYPASS applies to the write presented in the same cycle as the read request.
- Read ports are fully independent: any number may read the same address in the same cycle.
- Out-of-range addresses are impossible, since DEPTH = 2**WIDTH_ADDR.
- No X propagates from storage after reset. Reads before any write return 0.

Test Plan:
1. Reset then read: assert rst 1 cycle; read addresses 0, 5, 31 on both ports -> rd_data=0, rd_valid tracks rd_en (0 during rst).
2. Basic write/read, RD_REG=0: write 0xDEADBEEF to addr 7 in cycle n -> port 0 reads addr 7 in cycle n+1 and gets 0xDEADBEEF. Reading addr 7 in cycle n itself gets 0xDEADBEEF when BYPASS=1 and the old value when BYPASS=0.
3. Zero register: write 0x12345678 to addr 0 -> reads of addr 0 return 0, including the same-cycle bypassed read.
4. Write collision, NUM_WR=2: both ports write addr 3 with 0xAAAA0000 (port 0) and 0x5555FFFF (port 1) -> addr 3 = 0x5555FFFF; wr_collision=1 for exactly the next cycle.
5. Registered read, RD_REG=1: rd_en=1 for addr 9 (holding 0x0000CAFE) in cycle n -> rd_data=0x0000CAFE and rd_valid=1 in cycle n+1. With rd_en=0 in cycle n+1, rd_data holds in n+2 and rd_valid=0.
6. Reset mid-write: wr_en=1 to addr 4 with 0xFFFFFFFF together with rst=1 -> addr 4 reads 0 afterwards; wr_collision=0.
